// File: rtl/seq_control.sv
// seq_control: eight-phase instruction sequencer for a small accumulator CPU.
// Optional build macro SEQ_CONTROL_WAIT_EN enables memory wait-state stalling
// and the bus timeout; without it mem_rdy is ignored and bus_err is tied low.
module seq_control #(
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            zero,
  input  logic [OP_W-1:0] op,
  input  logic            mem_rdy,
  input  logic            run,
  output logic            sel,
  output logic            rd,
  output logic            ld_ir,
  output logic            inc,
  output logic            ld_acc,
  output logic            ld_pc,
  output logic            wr,
  output logic            dout_en,
  output logic            halt,
  output logic            bus_err,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_strb;
  logic [8:0] w_strb;
  logic       w_hlt, w_skz, w_sto, w_jmp, w_aluop;

  // Opcode decode; full-width compares make every op >= 8 a NOP.
  always_comb begin
    w_hlt   = (op == OP_HLT);
    w_skz   = (op == OP_SKZ);
    w_sto   = (op == OP_STO);
    w_jmp   = (op == OP_JMP);
    w_aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  end

`ifdef SEQ_CONTROL_WAIT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  logic [7:0] r_wait_cnt;
  logic       r_bus_err;
  logic       w_wait_pt;
  logic       w_stall;
  logic       w_timeout;
`else
  logic [8:0] w_unused;
  assign w_unused = {mem_rdy, 8'(TIMEOUT)};
`endif

  // Next-phase selection, including halt/restart and memory wait stalls.
  always_comb begin
    w_next = r_state;
    case (r_state)
      INST_ADDR:  w_next = INST_FETCH;
      INST_FETCH: w_next = INST_LOAD;
      INST_LOAD:  w_next = IDLE;
      IDLE:       w_next = OP_ADDR;
      OP_ADDR:    w_next = w_hlt ? HALTED : OP_FETCH;
      OP_FETCH:   w_next = ALU_OP;
      ALU_OP:     w_next = STORE;
      STORE:      w_next = INST_ADDR;
      HALTED:     w_next = run ? INST_ADDR : HALTED;
      default:    w_next = INST_ADDR;
    endcase
`ifdef SEQ_CONTROL_WAIT_EN
    w_stall   = 1'b0;
    w_timeout = 1'b0;
    w_wait_pt = (r_state == INST_FETCH) ||
                ((r_state == OP_FETCH) && w_aluop) ||
                ((r_state == STORE) && w_sto);
    if (w_wait_pt && !mem_rdy) begin
      if (r_wait_cnt == TMO) begin
        w_next    = HALTED;
        w_timeout = 1'b1;
      end else begin
        w_next  = r_state;
        w_stall = 1'b1;
      end
    end
`endif
  end

  // Strobes are decoded from the phase being entered so the registered
  // outputs line up with the state register.
  always_comb begin
    w_strb = '0;
    case (w_next)
      INST_ADDR:        w_strb[8] = 1'b1;
      INST_FETCH:       w_strb[8:7] = 2'b11;
      INST_LOAD, IDLE:  w_strb[8:6] = 3'b111;
      OP_ADDR:          w_strb[5] = 1'b1;
      OP_FETCH:         w_strb[7] = w_aluop;
      ALU_OP: begin
        w_strb[7] = w_aluop;
        w_strb[5] = w_skz & zero;
        w_strb[3] = w_jmp;
        w_strb[1] = w_sto;
      end
      STORE: begin
        w_strb[7] = w_aluop;
        w_strb[4] = w_aluop;
        w_strb[3] = w_jmp;
        w_strb[2] = w_sto;
        w_strb[1] = w_sto;
      end
      HALTED:           w_strb[0] = 1'b1;
      default:          w_strb = '0;
    endcase
  end

  // Sequencer state, registered strobes, wait counter and sticky bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INST_ADDR;
      r_strb  <= 9'b1_0000_0000;
`ifdef SEQ_CONTROL_WAIT_EN
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_strb  <= w_strb;
`ifdef SEQ_CONTROL_WAIT_EN
      r_wait_cnt <= w_stall ? r_wait_cnt + 8'd1 : '0;
      if (w_timeout)
        r_bus_err <= 1'b1;
`endif
    end
  end

  assign {sel, rd, ld_ir, inc, ld_acc, ld_pc, wr, dout_en, halt} = r_strb;
  assign state = r_state;
`ifdef SEQ_CONTROL_WAIT_EN
  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_control.sv
// Directed bench for seq_control (OP_W=4, TIMEOUT=4). Wait-state scenarios
// are included when SEQ_CONTROL_WAIT_EN is defined.
module tb_seq_control;

  logic       clk = 1'b0;
  logic       rst, zero, mem_rdy, run;
  logic [3:0] op;
  logic       sel, rd, ld_ir, inc, ld_acc, ld_pc, wr, dout_en, halt, bus_err;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  // Output vector order: sel rd ld_ir inc ld_acc ld_pc wr dout_en halt bus_err
  localparam logic [9:0] O_IA   = 10'b1000000000;
  localparam logic [9:0] O_IF   = 10'b1100000000;
  localparam logic [9:0] O_IL   = 10'b1110000000;
  localparam logic [9:0] O_INC  = 10'b0001000000;
  localparam logic [9:0] O_RD   = 10'b0100000000;
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_HALT = 10'b0000000010;

  always #5 clk = ~clk;

  seq_control #(.OP_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .zero(zero), .op(op), .mem_rdy(mem_rdy), .run(run),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc(inc), .ld_acc(ld_acc),
    .ld_pc(ld_pc), .wr(wr), .dout_en(dout_en), .halt(halt),
    .bus_err(bus_err), .state(state)
  );

  function automatic logic [13:0] obs();
    return {state, sel, rd, ld_ir, inc, ld_acc, ld_pc, wr, dout_en, halt, bus_err};
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 4'd2; zero = 1'b0; mem_rdy = 1'b1; run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs() !== {4'd0, O_IA}) begin
      n_err++;
      $display("FAIL reset: got %b want %b", obs(), {4'd0, O_IA});
    end
    rst = 1'b0; run = 1'b0;
  endtask

  task automatic test_add();
    logic [13:0] exp_v [8] = '{ {4'd1, O_IF}, {4'd2, O_IL}, {4'd3, O_IL}, {4'd4, O_INC},
                                {4'd5, O_RD}, {4'd6, O_RD}, {4'd7, 10'b0100100000},
                                {4'd0, O_IA} };
    op = 4'd2; zero = 1'b0; mem_rdy = 1'b1;
    pulse_reset();
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== exp_v[i]) begin
        n_err++;
        $display("FAIL add step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_skz(input logic z);
    logic [13:0] exp_v [8] = '{ {4'd1, O_IF}, {4'd2, O_IL}, {4'd3, O_IL}, {4'd4, O_INC},
                                {4'd5, O_NONE}, {4'd6, z ? O_INC : O_NONE},
                                {4'd7, O_NONE}, {4'd0, O_IA} };
    op = 4'd1; zero = z; mem_rdy = 1'b1;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== exp_v[i]) begin
        n_err++;
        $display("FAIL skz zero=%0b step %0d: got %b want %b", z, i, obs(), exp_v[i]);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sto_jmp();
    logic [13:0] sto_v [4] = '{ {4'd5, O_NONE}, {4'd6, 10'b0000000100},
                                {4'd7, 10'b0000001100}, {4'd0, O_IA} };
    logic [13:0] jmp_v [4] = '{ {4'd5, O_NONE}, {4'd6, 10'b0000010000},
                                {4'd7, 10'b0000010000}, {4'd0, O_IA} };
    op = 4'd6; mem_rdy = 1'b1;
    pulse_reset();
    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== sto_v[i]) begin
        n_err++;
        $display("FAIL sto step %0d: got %b want %b", i, obs(), sto_v[i]);
      end
    end
    op = 4'd7;
    pulse_reset();
    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== jmp_v[i]) begin
        n_err++;
        $display("FAIL jmp step %0d: got %b want %b", i, obs(), jmp_v[i]);
      end
    end
  endtask

  task automatic test_nop();
    logic [13:0] exp_v [8] = '{ {4'd1, O_IF}, {4'd2, O_IL}, {4'd3, O_IL}, {4'd4, O_INC},
                                {4'd5, O_NONE}, {4'd6, O_NONE}, {4'd7, O_NONE},
                                {4'd0, O_IA} };
    op = 4'd9; zero = 1'b1; mem_rdy = 1'b1;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== exp_v[i]) begin
        n_err++;
        $display("FAIL nop step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_halt();
    logic [13:0] exp_v [7] = '{ {4'd1, O_IF}, {4'd2, O_IL}, {4'd3, O_IL}, {4'd4, O_INC},
                                {4'd8, O_HALT}, {4'd8, O_HALT}, {4'd8, O_HALT} };
    op = 4'd0; mem_rdy = 1'b1; run = 1'b0;
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== exp_v[i]) begin
        n_err++;
        $display("FAIL halt step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    n_vec++;
    if (obs() !== {4'd0, O_IA}) begin
      n_err++;
      $display("FAIL halt_run: got %b want %b", obs(), {4'd0, O_IA});
    end
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (obs() !== {4'd8, O_HALT}) begin
      n_err++;
      $display("FAIL halt_again: got %b want %b", obs(), {4'd8, O_HALT});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (obs() !== {4'd0, O_IA}) begin
      n_err++;
      $display("FAIL halt_rst: got %b want %b", obs(), {4'd0, O_IA});
    end
  endtask

`ifdef SEQ_CONTROL_WAIT_EN
  task automatic test_store_wait();
    op = 4'd6; mem_rdy = 1'b1;
    pulse_reset();
    repeat (7) @(posedge clk);
    #1;
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (obs() !== {4'd7, 10'b0000001100}) begin
        n_err++;
        $display("FAIL store_wait cyc %0d: got %b want %b", i, obs(), {4'd7, 10'b0000001100});
      end
      if (i == 3) mem_rdy = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (obs() !== {4'd0, O_IA}) begin
      n_err++;
      $display("FAIL store_release: got %b want %b", obs(), {4'd0, O_IA});
    end
    repeat (7) @(posedge clk);
    #1;
    mem_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rdy = 1'b1;
    n_vec++;
    if (obs() !== {4'd0, O_IA}) begin
      n_err++;
      $display("FAIL store_rst: got %b want %b", obs(), {4'd0, O_IA});
    end
  endtask

  task automatic test_opfetch_wait();
    op = 4'd2; mem_rdy = 1'b1;
    pulse_reset();
    repeat (5) @(posedge clk);
    #1;
    mem_rdy = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (obs() !== {4'd5, O_RD}) begin
      n_err++;
      $display("FAIL opfetch_stall: got %b want %b", obs(), {4'd5, O_RD});
    end
    mem_rdy = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (obs() !== {4'd6, O_RD}) begin
      n_err++;
      $display("FAIL opfetch_go: got %b want %b", obs(), {4'd6, O_RD});
    end
    op = 4'd6;
    pulse_reset();
    repeat (5) @(posedge clk);
    #1;
    mem_rdy = 1'b0;
    @(posedge clk); #1;
    mem_rdy = 1'b1;
    n_vec++;
    if (obs() !== {4'd6, 10'b0000000100}) begin
      n_err++;
      $display("FAIL opfetch_sto_nowait: got %b want %b", obs(), {4'd6, 10'b0000000100});
    end
  endtask

  task automatic test_timeout();
    op = 4'd2; mem_rdy = 1'b0; run = 1'b0;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== {4'd1, O_IF}) begin
        n_err++;
        $display("FAIL timeout_hold cyc %0d: got %b want %b", i, obs(), {4'd1, O_IF});
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (obs() !== {4'd8, 10'b0000000011}) begin
      n_err++;
      $display("FAIL timeout_halt: got %b want %b", obs(), {4'd8, 10'b0000000011});
    end
    run = 1'b1; mem_rdy = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    n_vec++;
    if (obs() !== {4'd0, 10'b1000000001}) begin
      n_err++;
      $display("FAIL timeout_run: got %b want %b", obs(), {4'd0, 10'b1000000001});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (obs() !== {4'd0, O_IA}) begin
      n_err++;
      $display("FAIL timeout_rst: got %b want %b", obs(), {4'd0, O_IA});
    end
    mem_rdy = 1'b0;
    pulse_reset();
    repeat (5) @(posedge clk);
    #1;
    mem_rdy = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (obs() !== {4'd2, O_IL}) begin
      n_err++;
      $display("FAIL timeout_edge_rdy: got %b want %b", obs(), {4'd2, O_IL});
    end
  endtask
`else
  task automatic test_no_wait();
    logic [13:0] exp_v [8] = '{ {4'd1, O_IF}, {4'd2, O_IL}, {4'd3, O_IL}, {4'd4, O_INC},
                                {4'd5, O_NONE}, {4'd6, 10'b0000000100},
                                {4'd7, 10'b0000001100}, {4'd0, O_IA} };
    op = 4'd6; mem_rdy = 1'b0;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs() !== exp_v[i]) begin
        n_err++;
        $display("FAIL no_wait step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    mem_rdy = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1; zero = 1'b0; mem_rdy = 1'b1; run = 1'b0; op = 4'd0;
    test_reset();
    test_add();
    test_skz(1'b1);
    test_skz(1'b0);
    test_sto_jmp();
    test_nop();
    test_halt();
`ifdef SEQ_CONTROL_WAIT_EN
    test_store_wait();
    test_opfetch_wait();
    test_timeout();
`else
    test_no_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 The module SHALL have parameter OP_W, default 3, giving the opcode width (minimum 3).
REQ-002 The module SHALL have parameter TIMEOUT, default 15, giving the maximum number of memory wait cycles (1..255).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 zero  input  1  accumulator-zero flag.
REQ-006 op  input  OP_W  opcode from the instruction register.
REQ-007 mem_rdy  input  1  memory access complete.
REQ-008 run  input  1  restart request while halted.
REQ-009 sel, rd, ld_ir, inc, ld_acc, ld_pc, wr, dout_en  output  1 each  datapath strobes.
REQ-010 halt  output  1  CPU halted.
REQ-011 bus_err  output  1  memory timeout occurred.
REQ-012 state  output  4  current phase encoding.

Function
REQ-013 Opcodes SHALL be: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP; any op >= 8 SHALL be a NOP with no ld_acc, wr, ld_pc or halt.
REQ-014 ALUOP SHALL mean op is ADD, AND, XOR or LDA.
REQ-015 States SHALL be INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, HALTED=8.
REQ-016 The state register SHALL advance 0->1->...->7->0 one step per cycle unless it is stalled or halted.
REQ-017 Outputs SHALL be Moore-style, decoded from state, op and zero; all unlisted outputs are 0.
- INST_ADDR: sel.
- INST_FETCH: sel, rd.
- INST_LOAD, IDLE: sel, rd, ld_ir.
- OP_ADDR: inc.
- OP_FETCH: rd=ALUOP.
- ALU_OP: rd=ALUOP; inc=SKZ&zero; ld_pc=JMP; dout_en=STO.
- STORE: rd=ALUOP; ld_acc=ALUOP; ld_pc=JMP; wr=STO; dout_en=STO.
- HALTED: halt only (plus bus_err when latched).
REQ-018 In OP_ADDR with op==HLT, the next state SHALL be HALTED instead of OP_FETCH.
REQ-019 In HALTED, run=1 SHALL move to INST_ADDR on the next edge; run in any other state SHALL be ignored.
REQ-020 A wait point SHALL be INST_FETCH, OP_FETCH with rd=1, or STORE with wr=1.
REQ-021 At a wait point with mem_rdy=0, the state and all outputs SHALL hold, and the 8-bit wait counter SHALL increment.
REQ-022 The wait counter SHALL clear whenever the state advances.
REQ-023 If the wait counter equals TIMEOUT with mem_rdy=0, the next state SHALL be HALTED and bus_err SHALL set; if mem_rdy=1 in that same cycle, the access completes normally.
REQ-024 bus_err SHALL remain set until rst; run from HALTED with bus_err=1 SHALL still restart, and bus_err stays 1.
REQ-025 A wait point with mem_rdy=1 on its first cycle SHALL advance with zero stall, giving an 8-cycle instruction.

Reset
REQ-026 While rst=1 at an edge: state=INST_ADDR, wait counter=0, bus_err=0; this overrides stall, halt and run.
REQ-027 Post-reset outputs SHALL be sel=1, all others 0, state=0.
REQ-028 rst asserted mid-stall SHALL abandon the access with no wr pulse after the reset edge.

Configuration
REQ-029 With macro SEQ_CONTROL_WAIT_EN defined, wait-state stalling and the timeout of REQ-020 to REQ-024 SHALL be compiled in.
REQ-030 Without SEQ_CONTROL_WAIT_EN, mem_rdy SHALL be ignored, no wait counter SHALL exist, bus_err SHALL be tied to 0, and every instruction SHALL take exactly 8 cycles.

Verification
REQ-031 After reset, with mem_rdy=1 and op=ADD, 8 cycles -> state 0..7 in sequence, ld_acc=1 only in state 7, rd=1 in states 1,2,3,5,6,7.
REQ-032 op=SKZ: zero=1 -> inc=1 in states 4 and 6; zero=0 -> inc=1 only in state 4.
REQ-033 op=HLT -> state 0,1,2,3,4,8, then held at 8 with halt=1; run pulse -> state 0 next cycle.
REQ-034 op=STO (WAIT_EN), mem_rdy=0 for 3 cycles in STORE -> state held at 7 with wr=1 and dout_en=1 for 4 cycles, then state 0.
REQ-035 WAIT_EN, TIMEOUT=4, mem_rdy held 0 in INST_FETCH -> HALTED after 5 cycles at state 1, bus_err=1; rst -> bus_err=0, state=0.
REQ-036 OP_W=4, op=9 -> no ld_acc, wr, ld_pc or halt over a full 8-cycle instruction.
